count_mod: RTL and testbench

- Parametrised up/down counter; successor of the fixed 16-bit free-running counter.
- Adds configurable width, modulus, step size, wrap/saturate mode, count enable, synchronous load and terminal-count flag.
- Used as a general event/timebase counter inside datapath and control blocks.
- Direction-echo output is retained for drop-in compatibility.

---
 rtl/count_mod.sv | 91 +++++++++
 tb/tb_count_mod.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_mod.sv
// Parametrised up/down event/timebase counter: wrap or saturate, load, enable, terminal count.
// Latency: count_out, tc, up_count (and cmp_hit when COUNT_MOD_CMP_EN is defined) register on the same edge.
// Backpressure: none; en advances one step per clk, load takes priority over en.
module count_mod #(
    parameter int WIDTH    = 16,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             up_count,
    output logic             tc
`ifdef COUNT_MOD_CMP_EN
    ,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_hit
`endif
);

    // One extra bit keeps MAX_VAL+1 and every intermediate sum representable.
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MAX_P1 = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   nxt_x;
    logic [WIDTH-1:0] nxt_cnt;
    logic             nxt_tc;
    logic             unused_msb;

    assign cnt_x  = {1'b0, count_out};
    assign load_x = {1'b0, load_val};

    always_comb begin
        nxt_x  = cnt_x;
        nxt_tc = 1'b0;
        if (load) begin
            nxt_x = (load_x > MAX_X) ? MAX_X : load_x;
        end else if (en) begin
            if (!up_down) begin
                if (cnt_x <= MAX_X - STEP_X) begin
                    nxt_x = cnt_x + STEP_X;
                end else begin
                    nxt_tc = 1'b1;
                    nxt_x  = SATURATE ? MAX_X : (cnt_x + STEP_X - MAX_P1);
                end
            end else begin
                if (cnt_x >= STEP_X) begin
                    nxt_x = cnt_x - STEP_X;
                end else begin
                    nxt_tc = 1'b1;
                    nxt_x  = SATURATE ? '0 : (cnt_x + MAX_P1 - STEP_X);
                end
            end
        end
    end

    // Every branch lands in 0..MAX_VAL, so the top bit is always zero here.
    assign nxt_cnt    = nxt_x[WIDTH-1:0];
    assign unused_msb = nxt_x[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
            up_count  <= 1'b0;
            tc        <= 1'b0;
        end else begin
            count_out <= nxt_cnt;
            up_count  <= up_down;
            tc        <= nxt_tc;
        end
    end

`ifdef COUNT_MOD_CMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_hit <= 1'b0;
        end else begin
            cmp_hit <= (nxt_cnt == cmp_val);
        end
    end
`endif

endmodule

// File: tb/tb_count_mod.sv
// Scoreboard bench for count_mod: three instances (wrap step 1, wrap step 3, saturate step 1) share stimulus.
module tb_count_mod;

    localparam int MAXV = 9;
    localparam int CMPV = 4;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       up;
        logic       cmp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_down;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cmp_val;

    logic [3:0] cnt_o [3];
    logic       up_o  [3];
    logic       tc_o  [3];
    logic       cmp_o [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int m_cnt [3];
    int stp   [3] = '{1, 3, 1};
    bit sat   [3] = '{1'b0, 1'b0, 1'b1};

    int n_cmp = 0;
    int n_bad = 0;

    count_mod #(.WIDTH(4), .MAX_VAL(MAXV), .STEP(1), .SATURATE(1'b0)) u_wrap1 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count_out(cnt_o[0]), .up_count(up_o[0]), .tc(tc_o[0])
`ifdef COUNT_MOD_CMP_EN
        , .cmp_val(cmp_val), .cmp_hit(cmp_o[0])
`endif
    );

    count_mod #(.WIDTH(4), .MAX_VAL(MAXV), .STEP(3), .SATURATE(1'b0)) u_wrap3 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count_out(cnt_o[1]), .up_count(up_o[1]), .tc(tc_o[1])
`ifdef COUNT_MOD_CMP_EN
        , .cmp_val(cmp_val), .cmp_hit(cmp_o[1])
`endif
    );

    count_mod #(.WIDTH(4), .MAX_VAL(MAXV), .STEP(1), .SATURATE(1'b1)) u_sat1 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count_out(cnt_o[2]), .up_count(up_o[2]), .tc(tc_o[2])
`ifdef COUNT_MOD_CMP_EN
        , .cmp_val(cmp_val), .cmp_hit(cmp_o[2])
`endif
    );

`ifndef COUNT_MOD_CMP_EN
    initial begin
        cmp_o[0] = 1'b0;
        cmp_o[1] = 1'b0;
        cmp_o[2] = 1'b0;
    end
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push(int i, exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Reference model: plain integer arithmetic over the legal range 0..MAXV.
    function automatic void model(int i, bit e, bit ud, bit ld, int lv);
        int   nx;
        bit   t;
        exp_t x;
        t = 1'b0;
        if (ld) begin
            nx = (lv > MAXV) ? MAXV : lv;
        end else if (e && !ud) begin
            nx = m_cnt[i] + stp[i];
            if (nx > MAXV) begin
                t  = 1'b1;
                nx = sat[i] ? MAXV : nx % (MAXV + 1);
            end
        end else if (e) begin
            nx = m_cnt[i] - stp[i];
            if (nx < 0) begin
                t  = 1'b1;
                nx = sat[i] ? 0 : nx + MAXV + 1;
            end
        end else begin
            nx = m_cnt[i];
        end
        m_cnt[i] = nx;
        x.cnt = 4'(nx);
        x.tc  = t;
        x.up  = ud;
        x.cmp = (nx == CMPV);
        push(i, x);
    endfunction

    task automatic step(bit e, bit ud, bit ld, int lv);
        @(negedge clk);
        rst      = 1'b0;
        en       = e;
        up_down  = ud;
        load     = ld;
        load_val = 4'(lv);
        for (int i = 0; i < 3; i++) model(i, e, ud, ld, lv);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock arrives.
    task automatic async_reset();
        exp_t z;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst d%0d count", i), int'(cnt_o[i]), 0);
            chk($sformatf("async_rst d%0d tc", i), int'(tc_o[i]), 0);
            chk($sformatf("async_rst d%0d up", i), int'(up_o[i]), 0);
        end
        @(negedge clk);
        en   = 1'b0;
        load = 1'b0;
        z    = '0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            push(i, z);
        end
    endtask

    // Monitor: every clock presents a result, compared against the head of each queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                case (i)
                    0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (have) begin
                    chk($sformatf("d%0d count", i), int'(cnt_o[i]), int'(e.cnt));
                    chk($sformatf("d%0d tc", i), int'(tc_o[i]), int'(e.tc));
                    chk($sformatf("d%0d up_count", i), int'(up_o[i]), int'(e.up));
`ifdef COUNT_MOD_CMP_EN
                    chk($sformatf("d%0d cmp_hit", i), int'(cmp_o[i]), int'(e.cmp));
`endif
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        up_down  = 1'b0;
        load     = 1'b0;
        load_val = '0;
        cmp_val  = 4'(CMPV);
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("init d%0d count", i), int'(cnt_o[i]), 0);
            chk($sformatf("init d%0d tc", i), int'(tc_o[i]), 0);
            chk($sformatf("init d%0d up", i), int'(up_o[i]), 0);
        end

        step(1'b0, 1'b0, 1'b0, 0);
        // Wrap / saturate at the top bound.
        step(1'b0, 1'b0, 1'b1, 8);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);
        // Wrap at the bottom bound (step 3 instance lands on 8 then 5).
        step(1'b0, 1'b0, 1'b1, 1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 0);
        // Load beats enable, clamps to the top, then holds; direction echo.
        step(1'b1, 1'b0, 1'b1, 15);
        repeat (2) step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        // Compare hit while counting up from 2.
        step(1'b0, 1'b0, 1'b1, 2);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);
        // Reset in the middle of a count.
        step(1'b0, 1'b0, 1'b1, 5);
        async_reset();
        step(1'b1, 1'b0, 1'b0, 0);

        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(3) != 0), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), int'($urandom_range(15)));
        end

        step(1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
